// File: rtl/rsa_pkg.sv
// Shared constants and types for the RSA operand loader.
// Covers the word and address widths, the controller states and the operand word type.
package rsa_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int WORDS      = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  typedef logic [DATA_WIDTH-1:0] rsa_word_t;
endpackage

// File: rtl/rsa_operand_loader_if.sv
// Operand stream, core read port and status flags of the RSA operand loader.
// The master side drives the stream and the core read address; the slave side is the loader.
interface rsa_operand_loader_if;
  import rsa_pkg::*;

  logic                  startInput;
  logic                  word_valid;
  rsa_word_t             m_input;
  rsa_word_t             e_input;
  rsa_word_t             n_input;
  logic                  core_release;
  logic [ADDR_WIDTH-1:0] rd_addr;
  rsa_word_t             rd_m;
  rsa_word_t             rd_e;
  rsa_word_t             rd_n;
  logic                  in_ready;
  logic                  loaded;
  logic [ADDR_WIDTH-1:0] e_top_word;
  logic                  e_zero;
  logic                  n_even_err;

  modport master (
    output startInput, word_valid, m_input, e_input, n_input, core_release, rd_addr,
    input  rd_m, rd_e, rd_n, in_ready, loaded, e_top_word, e_zero, n_even_err
  );

  modport slave (
    input  startInput, word_valid, m_input, e_input, n_input, core_release, rd_addr,
    output rd_m, rd_e, rd_n, in_ready, loaded, e_top_word, e_zero, n_even_err
  );
endinterface

// File: rtl/rsa_word_bank.sv
// Word-addressed register file with one write port and one registered read port.
// The storage array is not reset; a read of the address being written returns the old word.
module rsa_word_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/rsa_operand_loader.sv
// Loads m/e/n operand words into three banks for the modular-exponentiation core.
// Tracks the top nonzero exponent word and flags an even modulus.
module rsa_operand_loader
  import rsa_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  rsa_operand_loader_if.slave bus
);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0] e_top_q, e_top_d;
  logic                  e_zero_q, e_zero_d;
  logic                  n_even_q, n_even_d;
  logic                  accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      e_top_q  <= '0;
      e_zero_q <= 1'b1;
      n_even_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      e_top_q  <= e_top_d;
      e_zero_q <= e_zero_d;
      n_even_q <= n_even_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    e_top_d  = e_top_q;
    e_zero_d = e_zero_q;
    n_even_d = n_even_q;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        // Flags restart from a clean slate on every new load.
        if (bus.startInput) begin
          state_d  = LOAD;
          wcnt_d   = '0;
          e_top_d  = '0;
          e_zero_d = 1'b1;
          n_even_d = 1'b0;
        end
      end
      LOAD: begin
        if (bus.word_valid) begin
          accept = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (bus.e_input != '0) begin
            e_top_d  = wcnt_q;
            e_zero_d = 1'b0;
          end
          if (wcnt_q == '0) n_even_d = ~bus.n_input[0];
          // Counter wraps to zero naturally as the last word is stored.
          if (&wcnt_q) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.core_release) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  rsa_word_bank #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank_m (
    .clk(clk), .rst_n(reset), .we_i(accept), .waddr_i(wcnt_q),
    .wdata_i(bus.m_input), .raddr_i(bus.rd_addr), .rdata_o(bus.rd_m)
  );

  rsa_word_bank #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank_e (
    .clk(clk), .rst_n(reset), .we_i(accept), .waddr_i(wcnt_q),
    .wdata_i(bus.e_input), .raddr_i(bus.rd_addr), .rdata_o(bus.rd_e)
  );

  rsa_word_bank #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank_n (
    .clk(clk), .rst_n(reset), .we_i(accept), .waddr_i(wcnt_q),
    .wdata_i(bus.n_input), .raddr_i(bus.rd_addr), .rdata_o(bus.rd_n)
  );

  assign bus.in_ready   = (state_q == LOAD);
  assign bus.loaded     = (state_q == DONE);
  assign bus.e_top_word = e_top_q;
  assign bus.e_zero     = e_zero_q;
  assign bus.n_even_err = n_even_q;
endmodule
